mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multicycle main-control FSM for the MIPS stub datapath. Decodes the instruction opcode and sequences fetch, decode, execute, memory and write-back. Each step drives the datapath mux/enable signals plus the 3-bit `alu_op` consumed directly by `alu_control`. Memory accesses use a ready handshake, so the FSM stalls on wait states.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset; forces state to FETCH immediately.
- `opcode`  in  6  instruction[31:26] from the instruction register (valid from DECODE onward).
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `zero`  in  1  ALU zero flag (used in BRANCH).
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a`  out  1 each  datapath controls; reset value 0.
- `alu_src_b`  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2; reset value 00.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target; reset value 00.
- `alu_op`  out  3  001 add, 010 subtract, 100 funct decode (alu_control encoding); reset value 001.
- `f_sel`  out  1  1 = datapath routes `opcode` onto alu_control `F` instead of funct; reset value 0.
- `illegal`  out  1  sticky unknown-opcode flag, cleared only by `rst`; reset value 0.
- `state`  out  4  current state encoding, for debug; reset value 0.

## Operation
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11. Codes 12–15 go to FETCH on the next edge.
- Outputs are Moore decodes of `state`, except the handshake-gated enables noted below. Unlisted outputs are 0. `alu_op` defaults to 001.
- FETCH:
  - Drive `mem_read`=1, `alu_src_b`=01, `alu_op`=001.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0, otherwise go to DECODE.
- DECODE:
  - Drive `alu_src_b`=11, `alu_op`=001 (branch target precompute).
  - Next state by opcode: 100011/101011 → MEM_ADDR; 000000 → EXEC; 000100 → BRANCH; 000010 → JUMP; 001000/001100/001101/001010 → IMM_EXEC.
  - Any other opcode sets `illegal` and goes to FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=001. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ:
  - Drive `mem_read`=1, `i_or_d`=1.
  - Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
- MEM_WRITE:
  - Drive `i_or_d`=1; `mem_write`=1 every cycle in the state.
  - Leave to FETCH on `mem_ready`.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=100, `f_sel`=0 → ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010, `pc_write_cond`=1, `pc_source`=01 → FETCH. The PC update is gated by `zero` in the datapath.
- JUMP: `pc_write`=1, `pc_source`=10 → FETCH.
- IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=100, `f_sel`=1 → IMM_WB.
- IMM_WB: `reg_write`=1, `reg_dst`=0 → FETCH.

## Timing
- Cycles per instruction, with zero wait states: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, j 3.
- Each cycle `mem_ready` is low in a waiting state adds exactly one cycle.
- `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE; it is ignored elsewhere.
- `opcode` is sampled only in DECODE and MEM_ADDR.
- `rst` asserted mid-instruction:
  - Outputs take reset values asynchronously.
  - No write enable may glitch high.
  - The first edge after deassertion evaluates FETCH.

## Configuration
- `MIPS_CTRL_IMM_EN` defined:
  - IMM_EXEC/IMM_WB are present.
  - Opcodes 001000, 001100, 001101, 001010 decode as above.
- `MIPS_CTRL_IMM_EN` undefined:
  - IMM_EXEC/IMM_WB are removed, and `f_sel` is tied 0.
  - Those four opcodes are illegal: DECODE sets `illegal` and returns to FETCH.

## Test plan
- Reset then lw (100011), `mem_ready` held 1 → state sequence 0,1,2,3,4,0. `reg_write`=`mem_to_reg`=1 only in state 4. `alu_op`=001 throughout.
- R-type (000000) → EXEC asserts `alu_op`=100, `f_sel`=0. ALU_WB asserts `reg_write`=1, `reg_dst`=1. Back in FETCH after 4 cycles.
- beq (000100) → BRANCH asserts `alu_op`=010, `pc_write_cond`=1, `pc_source`=01, for exactly 1 cycle.
- sw (101011) with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` high for 4 cycles, then FETCH. Total 7 cycles.
- Opcode 111111 → `illegal`=1 from the cycle after DECODE, FETCH follows, flag stays set until `rst`. With `MIPS_CTRL_IMM_EN` undefined, ori (001101) produces the same result. With it defined, ori produces IMM_EXEC with `alu_op`=100, `f_sel`=1.
- `rst` pulsed during MEM_READ → outputs at reset values within the same cycle, `state`=0, and a normal fetch resumes.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main-control FSM with memory ready handshake.
// Define MIPS_CTRL_IMM_EN to enable the I-type ALU path (IMM_EXEC/IMM_WB).
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       f_sel,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC      = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
`ifdef MIPS_CTRL_IMM_EN
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11
`else
    JUMP      = 4'd9
`endif
  } state_t;
  state_t cur, nxt;
  logic ill_set;
  logic unused_zero;
  assign unused_zero = zero;
  assign state = cur;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur     <= FETCH;
      illegal <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= illegal | ill_set;
    end
  // Outputs are forced to reset values while rst is high so no enable glitches.
  always_comb begin
    nxt           = FETCH;
    ill_set       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b001;
    f_sel         = 1'b0;
    if (!rst)
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          nxt       = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            6'b100011, 6'b101011: nxt = MEM_ADDR;
            6'b000000:            nxt = EXEC;
            6'b000100:            nxt = BRANCH;
            6'b000010:            nxt = JUMP;
`ifdef MIPS_CTRL_IMM_EN
            6'b001000, 6'b001100, 6'b001101, 6'b001010: nxt = IMM_EXEC;
`endif
            default:              ill_set = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt       = opcode == 6'b101011 ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          nxt      = mem_ready ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          nxt       = mem_ready ? FETCH : MEM_WRITE;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b100;
          nxt       = ALU_WB;
        end
        ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 3'b010;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
`ifdef MIPS_CTRL_IMM_EN
        IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b100;
          f_sel     = 1'b1;
          nxt       = IMM_WB;
        end
        IMM_WB: reg_write = 1'b1;
`endif
        default: nxt = FETCH;
      endcase
  end
endmodule
